control_unit: RTL and testbench
===============================

# control_unit

Multi-cycle instruction sequencer that drives the CPU data path. It fetches a 16-bit instruction and decodes it into the data path's control fields. For ALU instructions it pulses the register group, waits for the data path's `en_out` completion, then issues register write-enable and the PC update. Jumps, NOP and HALT are sequenced without an ALU pass.

## Interface
Parameters:
- `TIMEOUT`, 15: maximum cycles spent in WAIT before declaring a fault (4-bit counter, 1..15).

Ports:
- `clk`  in  1  system clock; all state changes on rising edge.
- `rst`  in  1  synchronous, active-low reset; one clock; reset is synchronous and active-low.
- `start`  in  1  level; leaves IDLE/HALT and begins fetching; ignored in any other state.
- `instr`  in  16  instruction word from instruction memory at the current `pc_out`.
- `instr_valid`  in  1  `instr` is valid this cycle.
- `en_out`  in  1  data path completion strobe (ALU result valid).
- `en_pc_pulse`  out  1  one-cycle PC update strobe.
- `pc_ctrl`  out  2  00 hold, 01 PC+1, 10 PC+signext(offset), 11 PC={8'h00,offset}.
- `en_in_reg_group`  out  1  one-cycle start strobe to the register group.
- `reg_en`  out  4  one-hot register write enable for `rd`; one cycle.
- `rd`, `rs`  out  2 each  register selects.
- `alu_in_sel`  out  1  0 = `rs` operand, 1 = `offset_addr` immediate.
- `alu_func`  out  3  000 PASSB, 001 ADD, 010 SUB, 011 AND, 100 OR, 101 XOR, 110 SHL, 111 SHR.
- `offset_addr`  out  8  immediate / jump offset.
- `halted`  out  1  high in HALT.
- `fault`  out  1  sticky; set on WAIT timeout.

## Operation
- Encoding: [15:12] opcode, [11:10] rd, [9:8] rs, [7:0] imm.
- Opcodes:
  - 0 NOP
  - 1 MOV (PASSB, sel 0)
  - 2 MVI (PASSB, sel 1)
  - 3 ADD
  - 4 ADDI (sel 1)
  - 5 SUB
  - 6 AND
  - 7 OR
  - 8 XOR
  - 9 SHL
  - A SHR
  - B JMPR (pc_ctrl 10)
  - C JMPA (pc_ctrl 11)
  - D, E: illegal, executed as NOP
  - F HALT
- States:
  - IDLE: `start` → FETCH.
  - FETCH: latch IR when `instr_valid`, then → DECODE; otherwise stay.
  - DECODE: register `rd`/`rs`/`alu_func`/`alu_in_sel`/`offset_addr` from IR. ALU op → EXEC; HALT → HALT; others → WB.
  - EXEC: `en_in_reg_group`=1 for exactly this cycle → WAIT.
  - WAIT: count cycles; `en_out`=1 → WB. Count reaches `TIMEOUT` without `en_out` → `fault`=1, → HALT, no register write, no PC update.
  - WB:
    - ALU op: `reg_en`=1<<rd, `en_pc_pulse`=1, `pc_ctrl`=01.
    - JMPR/JMPA: `en_pc_pulse`=1, `pc_ctrl`=10/11.
    - NOP/illegal: `en_pc_pulse`=1, `pc_ctrl`=01.
    - Then → FETCH.
  - HALT: `halted`=1; `start` → FETCH and clears `fault`. PC is not advanced on HALT.
- `rd`, `rs`, `alu_func`, `alu_in_sel`, `offset_addr` hold stable from the cycle after DECODE through WB.
- `en_out` outside WAIT is ignored.
- `en_out` coincident with the timeout cycle counts as completion; `fault` is not set.

## Timing
- Reset: state IDLE; every output 0 (`pc_ctrl`=00, `reg_en`=0000, `fault`=0, `halted`=0).
- Reset asserted mid-instruction aborts it; no strobe is emitted in the reset cycle or after.
- All outputs are registered (driven from state/IR registers).
- ALU instruction with `instr_valid` already high: FETCH 1, DECODE 1, EXEC 1, WAIT n≥1, WB 1 → 4+n cycles.
- Jump/NOP: 3 cycles (FETCH, DECODE, WB).
- `en_pc_pulse`, `reg_en` and `en_in_reg_group` are never high for more than one consecutive cycle.
- `reg_en` and `en_pc_pulse` are asserted in the same WB cycle.

## Structure
- Shared package `cpu_pkg`:
  - opcode constants
  - `alu_func` codes
  - `pc_ctrl` codes
  - FSM state enum
  - instruction field positions
- One sub-module, `instr_decoder`: combinational IR → {is_alu, is_jump, is_halt, alu_func, alu_in_sel, pc_ctrl}.
- The FSM, timeout counter and output registers live in `control_unit`.

## Test plan
- Reset held 2 cycles mid-WAIT → next cycle all outputs 0, state IDLE; no `reg_en` pulse follows.
- `start`, `instr`=16'h3500 (ADD r1,r1), `en_out` 3 cycles after the EXEC pulse → `reg_en`=0010, `en_pc_pulse`=1 and `pc_ctrl`=01 in the same cycle; `alu_func`=001, `alu_in_sel`=0 stable throughout.
- `instr`=16'h4A7F (ADDI r2,0x7F) → `alu_in_sel`=1, `offset_addr`=8'h7F, `reg_en`=0100.
- `instr`=16'hB0FE (JMPR −2) → no `en_in_reg_group`; WB on cycle 3 with `pc_ctrl`=10, `offset_addr`=8'hFE.
- ALU op with `en_out` never asserted → `fault`=1 and `halted`=1 after `TIMEOUT` WAIT cycles; no `reg_en`. Then `start` → `fault`=0, FETCH resumes.
- `instr`=16'hF000 → `halted`=1, no `en_pc_pulse`. `start` during a running instruction has no effect.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared opcodes, ALU/PC codes, FSM states and instruction field positions
package cpu_pkg;
   localparam logic [3:0] OP_NOP  = 4'h0, OP_MOV  = 4'h1, OP_MVI  = 4'h2, OP_ADD  = 4'h3,
                          OP_ADDI = 4'h4, OP_SUB  = 4'h5, OP_AND  = 4'h6, OP_OR   = 4'h7,
                          OP_XOR  = 4'h8, OP_SHL  = 4'h9, OP_SHR  = 4'hA, OP_JMPR = 4'hB,
                          OP_JMPA = 4'hC, OP_HALT = 4'hF;
   localparam logic [2:0] ALU_PASSB = 3'd0, ALU_ADD = 3'd1, ALU_SUB = 3'd2, ALU_AND = 3'd3,
                          ALU_OR    = 3'd4, ALU_XOR = 3'd5, ALU_SHL = 3'd6, ALU_SHR = 3'd7;
   localparam logic [1:0] PC_HOLD = 2'b00, PC_INC = 2'b01, PC_REL = 2'b10, PC_ABS = 2'b11;
   localparam int OP_MSB = 15, OP_LSB = 12, RD_MSB = 11, RD_LSB = 10;
   localparam int RS_MSB = 9, RS_LSB = 8, IMM_MSB = 7, IMM_LSB = 0;
   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_WAIT, S_WB, S_HALT} state_t;
endpackage

// File: rtl/instr_decoder.sv
// instr_decoder: combinational opcode classification and control field decode
module instr_decoder
   import cpu_pkg::*;
(
   input  logic [3:0] opcode,
   output logic       is_alu,
   output logic       is_jump,
   output logic       is_halt,
   output logic [2:0] alu_func,
   output logic       alu_in_sel,
   output logic [1:0] pc_ctrl
);
   always_comb begin
      is_alu = 1'b1;
      is_jump = 1'b0;
      is_halt = 1'b0;
      alu_func = ALU_PASSB;
      alu_in_sel = 1'b0;
      pc_ctrl = PC_INC;
      case (opcode)
         OP_MOV:  ;
         OP_MVI:  alu_in_sel = 1'b1;
         OP_ADD:  alu_func = ALU_ADD;
         OP_ADDI: begin alu_func = ALU_ADD; alu_in_sel = 1'b1; end
         OP_SUB:  alu_func = ALU_SUB;
         OP_AND:  alu_func = ALU_AND;
         OP_OR:   alu_func = ALU_OR;
         OP_XOR:  alu_func = ALU_XOR;
         OP_SHL:  alu_func = ALU_SHL;
         OP_SHR:  alu_func = ALU_SHR;
         OP_JMPR: begin is_alu = 1'b0; is_jump = 1'b1; pc_ctrl = PC_REL; end
         OP_JMPA: begin is_alu = 1'b0; is_jump = 1'b1; pc_ctrl = PC_ABS; end
         OP_HALT: begin is_alu = 1'b0; is_halt = 1'b1; pc_ctrl = PC_HOLD; end
         default: is_alu = 1'b0;
      endcase
   end
endmodule

// File: rtl/control_unit.sv
// control_unit: multi-cycle fetch/decode/execute sequencer driving the CPU data path
module control_unit
   import cpu_pkg::*;
#(
   parameter int TIMEOUT = 15
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [15:0] instr,
   input  logic        instr_valid,
   input  logic        en_out,
   output logic        en_pc_pulse,
   output logic [1:0]  pc_ctrl,
   output logic        en_in_reg_group,
   output logic [3:0]  reg_en,
   output logic [1:0]  rd,
   output logic [1:0]  rs,
   output logic        alu_in_sel,
   output logic [2:0]  alu_func,
   output logic [7:0]  offset_addr,
   output logic        halted,
   output logic        fault
);
   state_t      state, state_nx;
   logic [15:0] ir;
   logic [3:0]  cnt;
   logic        is_alu, is_jump, is_halt, dec_sel, timeout;
   logic [2:0]  dec_func;
   logic [1:0]  dec_pc;
   instr_decoder u_dec (
      .opcode(ir[OP_MSB:OP_LSB]),
      .is_alu(is_alu),
      .is_jump(is_jump),
      .is_halt(is_halt),
      .alu_func(dec_func),
      .alu_in_sel(dec_sel),
      .pc_ctrl(dec_pc)
   );
   // WAIT lasts at most TIMEOUT cycles; the last one still accepts en_out
   assign timeout = cnt == 4'(TIMEOUT - 1);
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   state_nx = start ? S_FETCH : S_IDLE;
         S_FETCH:  state_nx = instr_valid ? S_DECODE : S_FETCH;
         S_DECODE: state_nx = is_alu ? S_EXEC : is_halt ? S_HALT : S_WB;
         S_EXEC:   state_nx = S_WAIT;
         S_WAIT:   state_nx = en_out ? S_WB : timeout ? S_HALT : S_WAIT;
         S_WB:     state_nx = S_FETCH;
         S_HALT:   state_nx = start ? S_FETCH : S_HALT;
         default:  state_nx = S_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= S_IDLE;
         ir <= '0;
         cnt <= '0;
         fault <= 1'b0;
         rd <= '0;
         rs <= '0;
         alu_func <= '0;
         alu_in_sel <= 1'b0;
         offset_addr <= '0;
      end else begin
         state <= state_nx;
         cnt <= state == S_WAIT ? cnt + 4'd1 : 4'd0;
         if (state == S_FETCH && instr_valid) ir <= instr;
         if (state == S_WAIT && state_nx == S_HALT) fault <= 1'b1;
         else if (state == S_HALT && start) fault <= 1'b0;
         if (state == S_DECODE) begin
            rd <= ir[RD_MSB:RD_LSB];
            rs <= ir[RS_MSB:RS_LSB];
            alu_func <= dec_func;
            alu_in_sel <= dec_sel;
            offset_addr <= ir[IMM_MSB:IMM_LSB];
         end
      end
   end
   assign en_in_reg_group = state == S_EXEC;
   assign en_pc_pulse = state == S_WB;
   assign pc_ctrl = state != S_WB ? PC_HOLD : is_jump ? dec_pc : PC_INC;
   assign reg_en = (state == S_WB && is_alu) ? 4'b0001 << rd : 4'b0000;
   assign halted = state == S_HALT;
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: randomized scenario bench for control_unit against a cycle-indexed reference model
module tb_control_unit;
   localparam int T = 15;
   localparam logic [2:0] FN [16] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd2, 3'd3, 3'd4,
                                      3'd5, 3'd6, 3'd7, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
   typedef struct packed {
      logic       pcp;
      logic [1:0] pcc;
      logic       eig;
      logic [3:0] ren;
      logic [1:0] rd;
      logic [1:0] rs;
      logic       sel;
      logic [2:0] fn;
      logic [7:0] off;
      logic       hlt;
      logic       flt;
   } obs_t;
   logic clk = 1'b0, rst = 1'b0, start = 1'b0, instr_valid = 1'b0, en_out = 1'b0;
   logic [15:0] instr = '0;
   logic en_pc_pulse, en_in_reg_group, alu_in_sel, halted, fault;
   logic [1:0] pc_ctrl, rd, rs;
   logic [3:0] reg_en;
   logic [2:0] alu_func;
   logic [7:0] offset_addr;
   int checks = 0, failures = 0;
   obs_t obs [64];
   control_unit #(.TIMEOUT(T)) dut (
      .clk(clk), .rst(rst), .start(start), .instr(instr), .instr_valid(instr_valid),
      .en_out(en_out), .en_pc_pulse(en_pc_pulse), .pc_ctrl(pc_ctrl),
      .en_in_reg_group(en_in_reg_group), .reg_en(reg_en), .rd(rd), .rs(rs),
      .alu_in_sel(alu_in_sel), .alu_func(alu_func), .offset_addr(offset_addr),
      .halted(halted), .fault(fault)
   );
   always #5 clk = ~clk;
   function automatic obs_t sample();
      return '{en_pc_pulse, pc_ctrl, en_in_reg_group, reg_en, rd, rs, alu_in_sel, alu_func,
               offset_addr, halted, fault};
   endfunction
   function automatic bit is_alu_op(input logic [3:0] op);
      return op >= 4'h1 && op <= 4'hA;
   endfunction
   // Cycle i counts from the FETCH cycle in which the instruction is presented.
   function automatic obs_t model(input logic [15:0] ins, input int k, input int i);
      obs_t e;
      logic [3:0] op;
      e = '0;
      op = ins[15:12];
      e.rd = ins[11:10];
      e.rs = ins[9:8];
      e.off = ins[7:0];
      e.fn = FN[op];
      e.sel = op == 4'h2 || op == 4'h4;
      if (is_alu_op(op)) begin
         e.eig = i == 2;
         if (k > 0 && i == 3 + k) begin
            e.pcp = 1'b1;
            e.pcc = 2'b01;
            e.ren = 4'b0001 << ins[11:10];
         end
         if (k == 0 && i >= 3 + T) begin
            e.hlt = 1'b1;
            e.flt = 1'b1;
         end
      end else if (op == 4'hF) e.hlt = i >= 2;
      else if (i == 2) begin
         e.pcp = 1'b1;
         e.pcc = op == 4'hB ? 2'b10 : op == 4'hC ? 2'b11 : 2'b01;
      end
      return e;
   endfunction
   // Decoded fields are only defined from the cycle after DECODE through WB.
   function automatic obs_t mask(input logic [15:0] ins, input int k, input int i);
      obs_t m;
      int last;
      m = '1;
      last = !is_alu_op(ins[15:12]) ? 2 : k > 0 ? 3 + k : 2 + T;
      if (i < 2 || i > last) begin
         m.rd = '0; m.rs = '0; m.off = '0; m.fn = '0; m.sel = '0;
      end
      if (!is_alu_op(ins[15:12])) begin
         m.fn = '0; m.sel = '0;
      end
      return m;
   endfunction
   // k = WAIT cycle carrying en_out (0 = never); entered and left just after a falling edge in FETCH.
   task automatic run(input logic [15:0] ins, input int k, input int n);
      int start_lim;
      start_lim = ins[15:12] == 4'hF ? 2 : (is_alu_op(ins[15:12]) && k == 0) ? 3 + T : n;
      for (int i = 0; i < n; i++) begin
         obs[i] = sample();
         instr_valid = i == 0;
         instr = i == 0 ? ins : 16'($urandom);
         en_out = (k > 0 && i == 2 + k) ||
                  ((i < 3 || (k > 0 && i >= 3 + k)) && $urandom_range(0, 1) == 1);
         start = i < start_lim && $urandom_range(0, 1) == 1;
         @(negedge clk);
      end
      instr_valid = 1'b0;
      en_out = 1'b0;
      start = 1'b0;
   endtask
   task automatic go_fetch();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask
   task automatic test_reset();
      rst = 1'b0;
      for (int c = 0; c < 3; c++) begin
         if (c == 2) rst = 1'b1;
         @(negedge clk);
         checks++;
         if (sample() !== obs_t'('0)) begin
            failures++;
            $display("FAIL reset c=%0d got=%h exp=0", c, sample());
         end
      end
      go_fetch();
   endtask
   task automatic test_alu_add();
      obs_t mk;
      run(16'h3500, 3, 8);
      for (int i = 0; i < 8; i++) begin
         mk = mask(16'h3500, 3, i);
         checks++;
         if ((obs[i] & mk) !== (model(16'h3500, 3, i) & mk)) begin
            failures++;
            $display("FAIL add cyc=%0d got=%h exp=%h", i, obs[i] & mk, model(16'h3500, 3, i) & mk);
         end
      end
      checks++;
      if (obs[6].ren !== 4'b0010 || obs[6].pcp !== 1'b1 || obs[6].pcc !== 2'b01) begin
         failures++;
         $display("FAIL add_wb got=%h exp=ren 2 pulse 1 pc 1", obs[6]);
      end
   endtask
   task automatic test_addi();
      obs_t mk;
      int k;
      k = $urandom_range(1, 5);
      run(16'h4A7F, k, 5 + k);
      for (int i = 0; i < 5 + k; i++) begin
         mk = mask(16'h4A7F, k, i);
         checks++;
         if ((obs[i] & mk) !== (model(16'h4A7F, k, i) & mk)) begin
            failures++;
            $display("FAIL addi cyc=%0d got=%h exp=%h", i, obs[i] & mk, model(16'h4A7F, k, i) & mk);
         end
      end
   endtask
   task automatic test_jumps();
      logic [15:0] list [5] = '{16'hB0FE, 16'hC012, 16'h0000, 16'hD123, 16'hE456};
      obs_t mk;
      foreach (list[j]) begin
         run(list[j], 0, 4);
         for (int i = 0; i < 4; i++) begin
            mk = mask(list[j], 0, i);
            checks++;
            if ((obs[i] & mk) !== (model(list[j], 0, i) & mk)) begin
               failures++;
               $display("FAIL jump %h cyc=%0d got=%h exp=%h", list[j], i, obs[i] & mk,
                        model(list[j], 0, i) & mk);
            end
         end
      end
   endtask
   task automatic test_random();
      logic [15:0] ins;
      obs_t mk;
      int k, n;
      for (int j = 0; j < 20; j++) begin
         ins = {4'($urandom_range(0, 14)), 12'($urandom)};
         k = $urandom_range(1, 6);
         n = is_alu_op(ins[15:12]) ? 5 + k : 4;
         run(ins, k, n);
         for (int i = 0; i < n; i++) begin
            mk = mask(ins, k, i);
            checks++;
            if ((obs[i] & mk) !== (model(ins, k, i) & mk)) begin
               failures++;
               $display("FAIL rand %h cyc=%0d got=%h exp=%h", ins, i, obs[i] & mk, model(ins, k, i) & mk);
            end
         end
      end
   endtask
   task automatic test_timeout();
      logic [15:0] ins;
      obs_t mk;
      ins = {4'h5, 12'($urandom)};
      run(ins, 0, 5 + T);
      for (int i = 0; i < 5 + T; i++) begin
         mk = mask(ins, 0, i);
         checks++;
         if ((obs[i] & mk) !== (model(ins, 0, i) & mk)) begin
            failures++;
            $display("FAIL timeout cyc=%0d got=%h exp=%h", i, obs[i] & mk, model(ins, 0, i) & mk);
         end
      end
      go_fetch();
      checks++;
      if (fault !== 1'b0 || halted !== 1'b0) begin
         failures++;
         $display("FAIL fault_clear fault=%b halted=%b exp 0 0", fault, halted);
      end
      run(16'h1900, 1, 6);
      checks++;
      if (obs[4].ren !== 4'b0100 || obs[4].pcp !== 1'b1) begin
         failures++;
         $display("FAIL resume got=%h exp=ren 4 pulse 1", obs[4]);
      end
   endtask
   task automatic test_halt();
      obs_t mk;
      run(16'hF000, 0, 6);
      for (int i = 0; i < 6; i++) begin
         mk = mask(16'hF000, 0, i);
         checks++;
         if ((obs[i] & mk) !== (model(16'hF000, 0, i) & mk)) begin
            failures++;
            $display("FAIL halt cyc=%0d got=%h exp=%h", i, obs[i] & mk, model(16'hF000, 0, i) & mk);
         end
      end
      go_fetch();
      checks++;
      if (halted !== 1'b0 || en_pc_pulse !== 1'b0) begin
         failures++;
         $display("FAIL halt_exit halted=%b pulse=%b exp 0 0", halted, en_pc_pulse);
      end
   endtask
   task automatic test_reset_mid_wait();
      run(16'h3600, 0, 6);
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         if (c == 2) rst = 1'b1;
         en_out = c >= 2;
         @(negedge clk);
         checks++;
         if (sample() !== obs_t'('0)) begin
            failures++;
            $display("FAIL rst_wait c=%0d got=%h exp=0", c, sample());
         end
      end
      en_out = 1'b0;
      go_fetch();
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end
   initial begin
      test_reset();
      test_alu_add();
      test_addi();
      test_jumps();
      test_random();
      test_timeout();
      test_halt();
      test_reset_mid_wait();
      test_alu_add();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
